// File: rtl/snoop_lookup_unit.sv
// snoop_lookup_unit
//   Snoop-side tag/state lookup for the L1 data cache. It takes one snoop at a
//   time, reads the addressed set from the state_tag_ram, compares the tag
//   across all ways, applies the MOESI snoop transition to the lowest hit way,
//   writes that state back, and returns a hit/dirty response.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   snp_valid/ready        snoop request handshake (index, tag, type)
//   snp_type               00 BusRd, 01 BusRdX, 10 BusUpgr, 11 treated as BusRd
//   local_lock[_index]     set currently held by the local controller
//   ram_rd_en, ram_index   set read strobe and read/write index
//   ram_rd_tags/states     per-way tags and states, valid the cycle after ram_rd_en
//   ram_wr_en/wr_state     one-hot way write enable and new state
//   resp_*                 response handshake and result fields
//
// States
//   IDLE | waiting for a snoop; snp_ready unless the set is locked locally
//   RD   | ram_rd_en pulse for the latched index
//   CMP  | read data valid; compare tags, compute result and next state
//   WR   | write pulse to the hit way when the state changes
//   RESP | response held until resp_ready
module snoop_lookup_unit #(
  parameter int NUM_WAYS    = 4,
  parameter int TAG_WIDTH   = 22,
  parameter int INDEX_WIDTH = 6,
  parameter int STATE_WIDTH = 3,
  parameter logic [STATE_WIDTH-1:0] M = 3'b000,
  parameter logic [STATE_WIDTH-1:0] O = 3'b001,
  parameter logic [STATE_WIDTH-1:0] E = 3'b010,
  parameter logic [STATE_WIDTH-1:0] S = 3'b011,
  parameter logic [STATE_WIDTH-1:0] I = 3'b100,
  localparam int WAY_BITS = $clog2(NUM_WAYS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            snp_valid,
  output logic                            snp_ready,
  input  logic [INDEX_WIDTH-1:0]          snp_index,
  input  logic [TAG_WIDTH-1:0]            snp_tag,
  input  logic [1:0]                      snp_type,
  input  logic                            local_lock,
  input  logic [INDEX_WIDTH-1:0]          local_lock_index,
  output logic                            ram_rd_en,
  output logic [INDEX_WIDTH-1:0]          ram_index,
  input  logic [NUM_WAYS*TAG_WIDTH-1:0]   ram_rd_tags,
  input  logic [NUM_WAYS*STATE_WIDTH-1:0] ram_rd_states,
  output logic [NUM_WAYS-1:0]             ram_wr_en,
  output logic [STATE_WIDTH-1:0]          ram_wr_state,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic                            resp_hit,
  output logic [WAY_BITS-1:0]             resp_way,
  output logic [STATE_WIDTH-1:0]          resp_prev_state,
  output logic                            resp_supply,
  output logic                            resp_multi_hit
);

  typedef enum logic [2:0] {IDLE, RD, CMP, WR, RESP} state_t;

  state_t                 state;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [1:0]             type_q;

  logic [NUM_WAYS-1:0]    hit_vec;
  logic                   cmp_hit;
  logic                   cmp_multi;
  logic [WAY_BITS-1:0]    cmp_way;
  logic [STATE_WIDTH-1:0] cmp_prev;
  logic [STATE_WIDTH-1:0] cmp_next;

  // Ready is held low during reset so that no request is taken while the
  // FSM is being forced back to IDLE.
  assign snp_ready = !rst && (state == IDLE) &&
                     !(local_lock && (local_lock_index == snp_index));

  always_comb begin
    hit_vec  = '0;
    cmp_way  = '0;
    cmp_prev = I;
    for (int k = 0; k < NUM_WAYS; k++) begin
      hit_vec[k] = (ram_rd_states[k*STATE_WIDTH +: STATE_WIDTH] != I) &&
                   (ram_rd_tags[k*TAG_WIDTH +: TAG_WIDTH] == tag_q);
    end
    // Walk downwards so the lowest matching way is the one that sticks.
    for (int k = NUM_WAYS - 1; k >= 0; k--) begin
      if (hit_vec[k]) begin
        cmp_way  = WAY_BITS'(k);
        cmp_prev = ram_rd_states[k*STATE_WIDTH +: STATE_WIDTH];
      end
    end
    cmp_hit = |hit_vec;
    // More than one bit set: clearing the lowest set bit leaves something.
    cmp_multi = (hit_vec & (hit_vec - NUM_WAYS'(1))) != '0;

    cmp_next = cmp_prev;
    if (type_q == 2'b01 || type_q == 2'b10) begin
      cmp_next = I;
    end else begin
      case (cmp_prev)
        M:       cmp_next = O;
        E:       cmp_next = S;
        default: cmp_next = cmp_prev;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      tag_q           <= '0;
      type_q          <= '0;
      ram_rd_en       <= 1'b0;
      ram_index       <= '0;
      ram_wr_en       <= '0;
      ram_wr_state    <= I;
      resp_valid      <= 1'b0;
      resp_hit        <= 1'b0;
      resp_way        <= '0;
      resp_prev_state <= I;
      resp_supply     <= 1'b0;
      resp_multi_hit  <= 1'b0;
    end else begin
      ram_rd_en <= 1'b0;
      ram_wr_en <= '0;
      case (state)
        IDLE: begin
          if (snp_valid && snp_ready) begin
            ram_index <= snp_index;
            tag_q     <= snp_tag;
            type_q    <= snp_type;
            ram_rd_en <= 1'b1;
            state     <= RD;
          end
        end
        RD: begin
          state <= CMP;
        end
        CMP: begin
          resp_hit        <= cmp_hit;
          resp_way        <= cmp_way;
          resp_prev_state <= cmp_prev;
          resp_supply     <= cmp_hit && (cmp_prev == M || cmp_prev == O);
          resp_multi_hit  <= cmp_multi;
          if (cmp_hit && (cmp_next != cmp_prev)) begin
            ram_wr_en    <= NUM_WAYS'(1) << cmp_way;
            ram_wr_state <= cmp_next;
          end
          state <= WR;
        end
        WR: begin
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_lookup_unit.sv
// Testbench for snoop_lookup_unit (default parameters: 4 ways, 22-bit tags,
// 6-bit index). A small array models the state_tag_ram; table vectors cover
// the directed cases and random sets are checked against a reference model.
module tb_snoop_lookup_unit;

  localparam logic [2:0] SM = 3'b000;
  localparam logic [2:0] SO = 3'b001;
  localparam logic [2:0] SE = 3'b010;
  localparam logic [2:0] SS = 3'b011;
  localparam logic [2:0] SI = 3'b100;

  logic        clk;
  logic        rst;
  logic        snp_valid;
  logic        snp_ready;
  logic [5:0]  snp_index;
  logic [21:0] snp_tag;
  logic [1:0]  snp_type;
  logic        local_lock;
  logic [5:0]  local_lock_index;
  logic        ram_rd_en;
  logic [5:0]  ram_index;
  logic [87:0] ram_rd_tags;
  logic [11:0] ram_rd_states;
  logic [3:0]  ram_wr_en;
  logic [2:0]  ram_wr_state;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_hit;
  logic [1:0]  resp_way;
  logic [2:0]  resp_prev_state;
  logic        resp_supply;
  logic        resp_multi_hit;

  snoop_lookup_unit dut (
    .clk(clk), .rst(rst),
    .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_index(snp_index),
    .snp_tag(snp_tag), .snp_type(snp_type),
    .local_lock(local_lock), .local_lock_index(local_lock_index),
    .ram_rd_en(ram_rd_en), .ram_index(ram_index),
    .ram_rd_tags(ram_rd_tags), .ram_rd_states(ram_rd_states),
    .ram_wr_en(ram_wr_en), .ram_wr_state(ram_wr_state),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_way(resp_way), .resp_prev_state(resp_prev_state),
    .resp_supply(resp_supply), .resp_multi_hit(resp_multi_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: synchronous read, data valid the cycle after ram_rd_en.
  logic [21:0] mem_tag [64][4];
  logic [2:0]  mem_st  [64][4];
  logic [5:0]  rd_idx = '0;

  always @(posedge clk) if (ram_rd_en) rd_idx <= ram_index;

  always_comb begin
    ram_rd_tags   = '0;
    ram_rd_states = '0;
    for (int w = 0; w < 4; w++) begin
      ram_rd_tags[w*22 +: 22]  = mem_tag[rd_idx][w];
      ram_rd_states[w*3 +: 3]  = mem_st[rd_idx][w];
    end
  end

  typedef struct packed {
    logic       hit;
    logic [1:0] way;
    logic [2:0] prev;
    logic       supply;
    logic       multi;
    logic [3:0] wr_en;
    logic [2:0] wr_state;
  } exp_t;

  typedef struct packed {
    logic [5:0]  idx;
    logic [21:0] tag;
    logic [1:0]  typ;
    logic [3:0]  mask;   // ways whose stored tag equals tag
    logic [11:0] sts;    // {way3, way2, way1, way0}
    logic        hit;
    logic [1:0]  way;
    logic [2:0]  prev;
    logic        sup;
    logic        multi;
    logic [3:0]  wr_en;
    logic [2:0]  wr_st;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Reference: rules applied directly to the stored set contents.
  function automatic exp_t model(input logic [5:0] idx, input logic [21:0] tag,
                                 input logic [1:0] typ);
    exp_t e;
    int   q[$];
    logic [2:0] nxt;
    e = '0;
    e.prev     = SI;
    e.wr_state = SI;
    for (int w = 0; w < 4; w++)
      if (mem_st[idx][w] != SI && mem_tag[idx][w] == tag) q.push_back(w);
    if (q.size() > 0) begin
      e.hit    = 1'b1;
      e.way    = 2'(q[0]);
      e.prev   = mem_st[idx][q[0]];
      e.multi  = q.size() > 1;
      e.supply = (e.prev == SM) || (e.prev == SO);
      if (typ == 2'b01 || typ == 2'b10) nxt = SI;
      else if (e.prev == SM)            nxt = SO;
      else if (e.prev == SE)            nxt = SS;
      else                              nxt = e.prev;
      if (nxt != e.prev) begin
        e.wr_en    = 4'b0001 << q[0];
        e.wr_state = nxt;
      end
    end
    return e;
  endfunction

  task automatic apply_update(input logic [5:0] idx, input exp_t e);
    if (e.wr_en != 0) mem_st[idx][e.way] = e.wr_state;
  endtask

  // One complete snoop with cycle-by-cycle protocol checks.
  task automatic run_snoop(input logic [5:0] idx, input logic [21:0] tag,
                           input logic [1:0] typ, input exp_t e, input int hold,
                           input bit lock_mid, input bit expect_now);
    int waits;
    @(negedge clk);
    snp_valid = 1'b1; snp_index = idx; snp_tag = tag; snp_type = typ;
    waits = 0;
    #1;
    while (!snp_ready && waits < 40) begin
      @(negedge clk); #1; waits++;
    end
    if (!snp_ready) begin
      chk("accept_timeout", 32'(waits), 0);
      snp_valid = 1'b0;
      return;
    end
    if (expect_now) chk("accept_wait", 32'(waits), 0);
    @(posedge clk);
    @(negedge clk);   // RD cycle
    snp_valid = 1'b0; snp_index = ~idx; snp_tag = ~tag; snp_type = ~typ;
    chk("rd_en_T1", ram_rd_en, 1);
    chk("ram_index_T1", ram_index, idx);
    chk("wr_en_T1", ram_wr_en, 0);
    chk("resp_valid_T1", resp_valid, 0);
    chk("snp_ready_busy", snp_ready, 0);
    if (lock_mid) begin local_lock = 1'b1; local_lock_index = idx; end
    @(negedge clk);   // CMP cycle
    chk("rd_en_T2", ram_rd_en, 0);
    chk("wr_en_T2", ram_wr_en, 0);
    chk("resp_valid_T2", resp_valid, 0);
    @(negedge clk);   // WR cycle
    chk("wr_en_T3", ram_wr_en, e.wr_en);
    if (e.wr_en != 0) begin
      chk("wr_state_T3", ram_wr_state, e.wr_state);
      chk("wr_index_T3", ram_index, idx);
    end
    chk("resp_valid_T3", resp_valid, 0);
    @(negedge clk);   // RESP cycle
    chk("resp_valid_T4", resp_valid, 1);
    chk("wr_en_T4", ram_wr_en, 0);
    chk("resp_hit", resp_hit, e.hit);
    chk("resp_way", resp_way, e.way);
    chk("resp_prev", resp_prev_state, e.prev);
    chk("resp_supply", resp_supply, e.supply);
    chk("resp_multi", resp_multi_hit, e.multi);
    for (int h = 0; h < hold; h++) begin
      snp_valid = 1'b1; snp_index = idx + 6'd1;
      @(negedge clk); #1;
      chk("hold_valid", resp_valid, 1);
      chk("hold_hit", resp_hit, e.hit);
      chk("hold_way", resp_way, e.way);
      chk("hold_prev", resp_prev_state, e.prev);
      chk("hold_supply", resp_supply, e.supply);
      chk("hold_ready", snp_ready, 0);
    end
    snp_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    if (lock_mid) local_lock = 1'b0;
    #1;
    chk("resp_done", resp_valid, 0);
    chk("no_extra_rd", ram_rd_en, 0);
    chk("ready_idle", snp_ready, 1);
  endtask

  task automatic load_vec(input vec_t v);
    for (int w = 0; w < 4; w++) begin
      mem_tag[v.idx][w] = v.mask[w] ? v.tag : (v.tag ^ 22'h155 ^ 22'(w));
      mem_st[v.idx][w]  = v.sts[w*3 +: 3];
    end
  endtask

  function automatic exp_t vec_exp(input vec_t v);
    exp_t e;
    e.hit = v.hit; e.way = v.way; e.prev = v.prev; e.supply = v.sup;
    e.multi = v.multi; e.wr_en = v.wr_en; e.wr_state = v.wr_st;
    return e;
  endfunction

  vec_t vecs[10];

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    logic [5:0]  ridx;
    logic [21:0] rtag;
    logic [1:0]  rtyp;
    logic [2:0]  st_list [5];

    st_list[0] = SM; st_list[1] = SO; st_list[2] = SE; st_list[3] = SS; st_list[4] = SI;

    vecs[0] = '{idx:6'd5,  tag:22'h1A2B3, typ:2'b00, mask:4'b0100, sts:{SS,SM,SE,SO},
                hit:1, way:2'd2, prev:SM, sup:1, multi:0, wr_en:4'b0100, wr_st:SO};
    vecs[1] = '{idx:6'd7,  tag:22'h00111, typ:2'b01, mask:4'b1000, sts:{SE,SS,SI,SM},
                hit:1, way:2'd3, prev:SE, sup:0, multi:0, wr_en:4'b1000, wr_st:SI};
    vecs[2] = '{idx:6'd8,  tag:22'h3F0F0, typ:2'b01, mask:4'b0010, sts:{SI,SI,SS,SI},
                hit:1, way:2'd1, prev:SS, sup:0, multi:0, wr_en:4'b0010, wr_st:SI};
    vecs[3] = '{idx:6'd9,  tag:22'h12345, typ:2'b00, mask:4'b0001, sts:{SI,SI,SI,SS},
                hit:1, way:2'd0, prev:SS, sup:0, multi:0, wr_en:4'b0000, wr_st:SI};
    vecs[4] = '{idx:6'd10, tag:22'h2AAAA, typ:2'b00, mask:4'b1111, sts:{SI,SI,SI,SI},
                hit:0, way:2'd0, prev:SI, sup:0, multi:0, wr_en:4'b0000, wr_st:SI};
    vecs[5] = '{idx:6'd11, tag:22'h05555, typ:2'b10, mask:4'b1010, sts:{SS,SI,SS,SI},
                hit:1, way:2'd1, prev:SS, sup:0, multi:1, wr_en:4'b0010, wr_st:SI};
    vecs[6] = '{idx:6'd12, tag:22'h0BEEF, typ:2'b00, mask:4'b0001, sts:{SI,SI,SI,SO},
                hit:1, way:2'd0, prev:SO, sup:1, multi:0, wr_en:4'b0000, wr_st:SI};
    vecs[7] = '{idx:6'd13, tag:22'h0CAFE, typ:2'b11, mask:4'b0010, sts:{SI,SI,SE,SI},
                hit:1, way:2'd1, prev:SE, sup:0, multi:0, wr_en:4'b0010, wr_st:SS};
    vecs[8] = '{idx:6'd14, tag:22'h3FFFF, typ:2'b01, mask:4'b0011, sts:{SI,SI,SM,SI},
                hit:1, way:2'd1, prev:SM, sup:1, multi:0, wr_en:4'b0010, wr_st:SI};
    vecs[9] = '{idx:6'd63, tag:22'h00000, typ:2'b10, mask:4'b1000, sts:{SM,SI,SI,SI},
                hit:1, way:2'd3, prev:SM, sup:1, multi:0, wr_en:4'b1000, wr_st:SI};

    for (int i = 0; i < 64; i++)
      for (int w = 0; w < 4; w++) begin
        mem_tag[i][w] = '0;
        mem_st[i][w]  = SI;
      end

    rst = 1'b1; snp_valid = 1'b0; snp_index = '0; snp_tag = '0; snp_type = '0;
    local_lock = 1'b0; local_lock_index = '0; resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_snp_ready", snp_ready, 0);
    chk("rst_rd_en", ram_rd_en, 0);
    chk("rst_ram_index", ram_index, 0);
    chk("rst_wr_en", ram_wr_en, 0);
    chk("rst_wr_state", ram_wr_state, SI);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_hit", resp_hit, 0);
    chk("rst_resp_way", resp_way, 0);
    chk("rst_resp_prev", resp_prev_state, SI);
    chk("rst_resp_supply", resp_supply, 0);
    chk("rst_resp_multi", resp_multi_hit, 0);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      load_vec(vecs[i]);
      run_snoop(vecs[i].idx, vecs[i].tag, vecs[i].typ, vec_exp(vecs[i]), i % 4,
                i == 2, 1'b1);
    end

    // Locked set: ready stays low until the lock drops.
    load_vec(vecs[0]);
    local_lock = 1'b1; local_lock_index = 6'd5;
    @(negedge clk);
    snp_valid = 1'b1; snp_index = 6'd5; snp_tag = 22'h1A2B3; snp_type = 2'b00;
    for (int k = 0; k < 3; k++) begin
      #1 chk("lock_blocks", snp_ready, 0);
      @(negedge clk);
    end
    local_lock = 1'b0;
    #1 chk("lock_released", snp_ready, 1);
    snp_valid = 1'b0;
    e = model(6'd5, 22'h1A2B3, 2'b00);
    run_snoop(6'd5, 22'h1A2B3, 2'b00, e, 0, 1'b0, 1'b1);
    apply_update(6'd5, e);

    // Lock on another set does not block.
    load_vec(vecs[1]);
    local_lock = 1'b1; local_lock_index = 6'd6;
    run_snoop(vecs[1].idx, vecs[1].tag, vecs[1].typ, vec_exp(vecs[1]), 1, 1'b0, 1'b1);
    local_lock = 1'b0;

    // Reset while in CMP: request dropped, no write, no response.
    load_vec(vecs[0]);
    @(negedge clk);
    snp_valid = 1'b1; snp_index = 6'd5; snp_tag = 22'h1A2B3; snp_type = 2'b01;
    @(posedge clk);
    @(negedge clk);
    snp_valid = 1'b0;
    chk("rstmid_rd_en", ram_rd_en, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid_resp_valid", resp_valid, 0);
    chk("rstmid_wr_en", ram_wr_en, 0);
    chk("rstmid_ready", snp_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rstmid_no_wr", ram_wr_en, 0);
      chk("rstmid_no_resp", resp_valid, 0);
    end
    e = model(6'd5, 22'h1A2B3, 2'b00);
    run_snoop(6'd5, 22'h1A2B3, 2'b00, e, 0, 1'b0, 1'b1);
    apply_update(6'd5, e);

    // Random sets against the reference model, with follow-up snoops that
    // see the state left by the previous one.
    for (int it = 0; it < 40; it++) begin
      ridx = 6'($urandom_range(0, 63));
      rtag = 22'($urandom);
      for (int w = 0; w < 4; w++) begin
        case ($urandom_range(0, 2))
          0:       mem_tag[ridx][w] = rtag;
          1:       mem_tag[ridx][w] = rtag ^ 22'h1;
          default: mem_tag[ridx][w] = 22'($urandom);
        endcase
        mem_st[ridx][w] = st_list[$urandom_range(0, 4)];
      end
      rtyp = 2'($urandom_range(0, 3));
      e = model(ridx, rtag, rtyp);
      run_snoop(ridx, rtag, rtyp, e, $urandom_range(0, 2), 1'b0, 1'b1);
      apply_update(ridx, e);
      if ($urandom_range(0, 1) == 1) begin
        rtyp = 2'($urandom_range(0, 3));
        e = model(ridx, rtag, rtyp);
        run_snoop(ridx, rtag, rtyp, e, 0, 1'b0, 1'b1);
        apply_update(ridx, e);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
